// File: rtl/passcode_ctrl.sv
// Door-lock sequencing controller: collects keypad digits, checks them against the
// stored code, and handles relock timing, failure lockout, entry timeout and code change.
module passcode_ctrl #(
  parameter int                    CODE_LEN    = 4,
  parameter logic [4*CODE_LEN-1:0] DEF_CODE    = 16'h1234,
  parameter int                    MAX_FAIL    = 3,
  parameter int                    OPEN_CYC    = 1000,
  parameter int                    LOCKOUT_CYC = 5000,
  parameter int                    ENTRY_TO    = 2000,
  parameter int                    TMR_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps_start,
  input  logic                          ps_end,
  input  logic                          key_vld,
  input  logic [3:0]                    key_num,
  output logic                          door_open,
  output logic [1:0]                    seg_out,
  output logic [2:0]                    state_out,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
  output logic                          alarm
);

  localparam int CODE_W = 4 * CODE_LEN;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [TMR_W-1:0]  OPEN_LD  = TMR_W'(OPEN_CYC);
  localparam logic [TMR_W-1:0]  LOCK_LD  = TMR_W'(LOCKOUT_CYC);
  localparam logic [TMR_W-1:0]  ENTRY_LD = TMR_W'(ENTRY_TO);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CODE_LEN);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_SETCODE = 3'd6
  } state_t;

  state_t              state_reg, state_next;
  logic [CODE_W-1:0]   code_reg, code_next;
  logic [CODE_W-1:0]   entry_reg, entry_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                ovf_reg, ovf_next;
  logic [TMR_W-1:0]    timer_reg, timer_next;
  logic [FAIL_W-1:0]   fail_reg, fail_next;
  logic                door_open_reg, door_open_next;
  logic                alarm_reg, alarm_next;
  logic [1:0]          seg_reg, seg_next;

  logic [CODE_W-1:0]   entry_shift;
  logic [CODE_LEN-1:0] digit_eq;
  logic                key_ok;
  logic                entry_full;
  logic                match;
  logic                timer_expire;
  logic [TMR_W-1:0]    timer_dec;
  logic [FAIL_W-1:0]   fail_inc;

  // New digit enters the LS nibble; a single-digit code just replaces it.
  generate
    if (CODE_LEN == 1) begin : g_shift_one
      assign entry_shift = key_num;
    end else begin : g_shift_many
      assign entry_shift = {entry_reg[CODE_W-5:0], key_num};
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < CODE_LEN; gi++) begin : g_digit_cmp
      assign digit_eq[gi] = (entry_reg[4*gi +: 4] == code_reg[4*gi +: 4]);
    end
  endgenerate

  assign key_ok       = key_vld && (key_num <= 4'd9);
  assign entry_full   = (cnt_reg == CNT_FULL) && !ovf_reg;
  assign match        = entry_full && (&digit_eq);
  assign timer_dec    = (timer_reg == '0) ? '0 : timer_reg - 1'b1;
  // A value of 0 also counts as expired so a timed state can never stall.
  assign timer_expire = (timer_reg <= TMR_W'(1));
  assign fail_inc     = fail_reg + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      code_reg      <= DEF_CODE;
      entry_reg     <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      timer_reg     <= '0;
      fail_reg      <= '0;
      door_open_reg <= 1'b0;
      alarm_reg     <= 1'b0;
      seg_reg       <= 2'b00;
    end else begin
      state_reg     <= state_next;
      code_reg      <= code_next;
      entry_reg     <= entry_next;
      cnt_reg       <= cnt_next;
      ovf_reg       <= ovf_next;
      timer_reg     <= timer_next;
      fail_reg      <= fail_next;
      door_open_reg <= door_open_next;
      alarm_reg     <= alarm_next;
      seg_reg       <= seg_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    entry_next = entry_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    timer_next = timer_dec;
    fail_next  = fail_reg;

    case (state_reg)
      S_IDLE: begin
        if (ps_start) begin
          state_next = S_ENTRY;
          entry_next = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          timer_next = ENTRY_LD;
        end
      end

      // Digit capture is shared; only the ps_end action differs.
      S_ENTRY, S_SETCODE: begin
        if (ps_start) begin
          entry_next = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          timer_next = ENTRY_LD;
        end else if (ps_end) begin
          if (state_reg == S_ENTRY) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_IDLE;
            if (entry_full) begin
              code_next = entry_reg;
            end
          end
        end else if (key_ok) begin
          entry_next = entry_shift;
          timer_next = ENTRY_LD;
          if (cnt_reg == CNT_FULL) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (timer_expire) begin
          state_next = S_IDLE;
        end
      end

      S_CHECK: begin
        if (match) begin
          state_next = S_OPEN;
          fail_next  = '0;
          timer_next = OPEN_LD;
        end else begin
          fail_next = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_next = S_LOCKOUT;
            timer_next = LOCK_LD;
          end else begin
            state_next = S_FAIL;
          end
        end
      end

      S_FAIL: begin
        state_next = S_IDLE;
      end

      S_OPEN: begin
        if (ps_start) begin
          state_next = S_SETCODE;
          entry_next = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          timer_next = ENTRY_LD;
        end else if (ps_end || timer_expire) begin
          state_next = S_IDLE;
        end
      end

      S_LOCKOUT: begin
        if (timer_expire) begin
          state_next = S_IDLE;
          fail_next  = '0;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change together with state_reg.
  always_comb begin
    door_open_next = (state_next == S_OPEN);
    alarm_next     = (state_next == S_LOCKOUT);
    seg_next       = 2'b00;
    case (state_next)
      S_OPEN:    seg_next = 2'b01;
      S_FAIL:    seg_next = 2'b10;
      S_LOCKOUT: seg_next = 2'b11;
      default:   seg_next = 2'b00;
    endcase
  end

  assign door_open = door_open_reg;
  assign alarm     = alarm_reg;
  assign seg_out   = seg_reg;
  assign state_out = state_reg;
  assign fail_cnt  = fail_reg;

endmodule

// File: tb/tb_passcode_ctrl.sv
// Directed bench for passcode_ctrl with short timer loads; one task per scenario.
module tb_passcode_ctrl;

  logic       clk;
  logic       rst;
  logic       ps_start;
  logic       ps_end;
  logic       key_vld;
  logic [3:0] key_num;
  logic       door_open;
  logic [1:0] seg_out;
  logic [2:0] state_out;
  logic [1:0] fail_cnt;
  logic       alarm;

  int n_checks = 0;
  int n_pass   = 0;

  passcode_ctrl #(
    .CODE_LEN(4), .DEF_CODE(16'h1234), .MAX_FAIL(3),
    .OPEN_CYC(10), .LOCKOUT_CYC(20), .ENTRY_TO(50), .TMR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .ps_start(ps_start), .ps_end(ps_end),
    .key_vld(key_vld), .key_num(key_num), .door_open(door_open),
    .seg_out(seg_out), .state_out(state_out), .fail_cnt(fail_cnt), .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ps_start = 1'b1; tick(); ps_start = 1'b0;
  endtask

  task automatic pulse_end();
    ps_end = 1'b1; tick(); ps_end = 1'b0;
  endtask

  task automatic send_keys(input logic [31:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      key_vld = 1'b1;
      key_num = c[4*(n-1-i) +: 4];
      tick();
      key_vld = 1'b0;
    end
  endtask

  // Leaves the DUT in CHECK.
  task automatic try_code(input logic [31:0] c, input int n);
    pulse_start();
    send_keys(c, n);
    pulse_end();
  endtask

  task automatic test_reset();
    n_checks++; if (state_out !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_out); else n_pass++;
    n_checks++; if (door_open !== 1'b0) $display("FAIL reset_door: got %b expected 0", door_open); else n_pass++;
    n_checks++; if (seg_out !== 2'b00) $display("FAIL reset_seg: got %b expected 00", seg_out); else n_pass++;
    n_checks++; if (alarm !== 1'b0) $display("FAIL reset_alarm: got %b expected 0", alarm); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd0) $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); else n_pass++;
    $display("reset: state=%0d door=%b seg=%b alarm=%b fail=%0d", state_out, door_open, seg_out, alarm, fail_cnt);
  endtask

  task automatic test_open();
    int n;
    try_code(32'h1234, 4);
    n_checks++; if (state_out !== 3'd2) $display("FAIL open_check_state: got %0d expected 2", state_out); else n_pass++;
    tick();
    n_checks++; if (state_out !== 3'd3) $display("FAIL open_state: got %0d expected 3", state_out); else n_pass++;
    n_checks++; if (seg_out !== 2'b01) $display("FAIL open_seg: got %b expected 01", seg_out); else n_pass++;
    n = 0;
    while (door_open === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    n_checks++; if (n !== 10) $display("FAIL open_dwell: got %0d expected 10", n); else n_pass++;
    n_checks++; if (state_out !== 3'd0) $display("FAIL open_relock_state: got %0d expected 0", state_out); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd0) $display("FAIL open_fail_cnt: got %0d expected 0", fail_cnt); else n_pass++;
    $display("open 1234: door_open cycles=%0d", n);
  endtask

  task automatic test_fail_lockout();
    int n;
    for (int t = 1; t <= 2; t++) begin
      try_code(32'h1235, 4);
      tick();
      n_checks++; if (state_out !== 3'd4) $display("FAIL fail_state: got %0d expected 4", state_out); else n_pass++;
      n_checks++; if (seg_out !== 2'b10) $display("FAIL fail_seg: got %b expected 10", seg_out); else n_pass++;
      n_checks++; if (fail_cnt !== 2'(t)) $display("FAIL fail_cnt_inc: got %0d expected %0d", fail_cnt, t); else n_pass++;
      tick();
      n_checks++; if (state_out !== 3'd0) $display("FAIL fail_to_idle: got %0d expected 0", state_out); else n_pass++;
      $display("wrong code try %0d: fail_cnt=%0d", t, fail_cnt);
    end
    try_code(32'h1235, 4);
    tick();
    n_checks++; if (state_out !== 3'd5) $display("FAIL lock_state: got %0d expected 5", state_out); else n_pass++;
    n_checks++; if (seg_out !== 2'b11) $display("FAIL lock_seg: got %b expected 11", seg_out); else n_pass++;
    n = 0;
    while (alarm === 1'b1 && n < 100) begin
      n++;
      ps_start = (n == 5);
      tick();
    end
    ps_start = 1'b0;
    n_checks++; if (n !== 20) $display("FAIL lock_dwell: got %0d expected 20", n); else n_pass++;
    n_checks++; if (state_out !== 3'd0) $display("FAIL lock_exit_state: got %0d expected 0", state_out); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd0) $display("FAIL lock_exit_fail_cnt: got %0d expected 0", fail_cnt); else n_pass++;
    $display("lockout: alarm cycles=%0d", n);
  endtask

  task automatic test_ovf_short();
    try_code(32'h12344, 5);
    tick();
    n_checks++; if (state_out !== 3'd4) $display("FAIL ovf_state: got %0d expected 4", state_out); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd1) $display("FAIL ovf_fail_cnt: got %0d expected 1", fail_cnt); else n_pass++;
    tick();
    try_code(32'h123, 3);
    tick();
    n_checks++; if (state_out !== 3'd4) $display("FAIL short_state: got %0d expected 4", state_out); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd2) $display("FAIL short_fail_cnt: got %0d expected 2", fail_cnt); else n_pass++;
    tick();
    try_code(32'h12C34, 5);
    tick();
    n_checks++; if (state_out !== 3'd3) $display("FAIL badkey_state: got %0d expected 3", state_out); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd0) $display("FAIL badkey_fail_cnt: got %0d expected 0", fail_cnt); else n_pass++;
    pulse_end();
    n_checks++; if (state_out !== 3'd0) $display("FAIL end_relock: got %0d expected 0", state_out); else n_pass++;
    $display("ovf/short/ignored-key: state=%0d fail=%0d", state_out, fail_cnt);
  endtask

  task automatic test_setcode();
    try_code(32'h1234, 4);
    tick();
    n_checks++; if (state_out !== 3'd3) $display("FAIL set_open: got %0d expected 3", state_out); else n_pass++;
    pulse_start();
    n_checks++; if (state_out !== 3'd6) $display("FAIL set_state: got %0d expected 6", state_out); else n_pass++;
    n_checks++; if (door_open !== 1'b0) $display("FAIL set_door: got %b expected 0", door_open); else n_pass++;
    send_keys(32'h9876, 4);
    pulse_end();
    n_checks++; if (state_out !== 3'd0) $display("FAIL set_done: got %0d expected 0", state_out); else n_pass++;
    try_code(32'h1234, 4);
    tick();
    n_checks++; if (state_out !== 3'd4) $display("FAIL old_code_rejected: got %0d expected 4", state_out); else n_pass++;
    tick();
    try_code(32'h9876, 4);
    tick();
    n_checks++; if (state_out !== 3'd3) $display("FAIL new_code_opens: got %0d expected 3", state_out); else n_pass++;
    pulse_end();
    rst = 1'b0; #2; rst = 1'b1;
    tick();
    try_code(32'h1234, 4);
    tick();
    n_checks++; if (state_out !== 3'd3) $display("FAIL def_code_restored: got %0d expected 3", state_out); else n_pass++;
    pulse_end();
    $display("setcode 9876 then reset: state=%0d", state_out);
  endtask

  task automatic test_timeout();
    int n;
    try_code(32'h1111, 4);
    tick();
    tick();
    n_checks++; if (fail_cnt !== 2'd1) $display("FAIL to_pre_fail_cnt: got %0d expected 1", fail_cnt); else n_pass++;
    pulse_start();
    send_keys(32'h1, 1);
    n = 0;
    while (state_out === 3'd1 && n < 200) begin
      n++;
      tick();
    end
    n_checks++; if (n !== 50) $display("FAIL to_dwell: got %0d expected 50", n); else n_pass++;
    n_checks++; if (state_out !== 3'd0) $display("FAIL to_state: got %0d expected 0", state_out); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd1) $display("FAIL to_fail_cnt: got %0d expected 1", fail_cnt); else n_pass++;
    $display("entry timeout: cycles=%0d fail=%0d", n, fail_cnt);
    pulse_start();
    send_keys(32'h12, 2);
    ps_start = 1'b1; ps_end = 1'b1;
    tick();
    ps_start = 1'b0; ps_end = 1'b0;
    n_checks++; if (state_out !== 3'd1) $display("FAIL prio_state: got %0d expected 1", state_out); else n_pass++;
    send_keys(32'h1234, 4);
    pulse_end();
    tick();
    n_checks++; if (state_out !== 3'd3) $display("FAIL prio_restart_open: got %0d expected 3", state_out); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd0) $display("FAIL prio_fail_cnt: got %0d expected 0", fail_cnt); else n_pass++;
    pulse_end();
    $display("start+end same cycle: restart then open ok");
  endtask

  task automatic test_async_reset();
    try_code(32'h1234, 4);
    tick(); tick(); tick();
    n_checks++; if (door_open !== 1'b1) $display("FAIL ar_open_pre: got %b expected 1", door_open); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (door_open !== 1'b0) $display("FAIL ar_door: got %b expected 0", door_open); else n_pass++;
    n_checks++; if (state_out !== 3'd0) $display("FAIL ar_open_state: got %0d expected 0", state_out); else n_pass++;
    #1 rst = 1'b1;
    tick();
    for (int t = 0; t < 2; t++) begin
      try_code(32'h5555, 4);
      tick(); tick();
    end
    try_code(32'h5555, 4);
    tick(); tick(); tick();
    n_checks++; if (alarm !== 1'b1) $display("FAIL ar_lock_pre: got %b expected 1", alarm); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (alarm !== 1'b0) $display("FAIL ar_alarm: got %b expected 0", alarm); else n_pass++;
    n_checks++; if (state_out !== 3'd0) $display("FAIL ar_lock_state: got %0d expected 0", state_out); else n_pass++;
    n_checks++; if (fail_cnt !== 2'd0) $display("FAIL ar_fail_cnt: got %0d expected 0", fail_cnt); else n_pass++;
    #1 rst = 1'b1;
    tick();
    $display("async reset mid-OPEN and mid-LOCKOUT: door=%b alarm=%b", door_open, alarm);
  endtask

  initial begin
    rst = 1'b0; ps_start = 1'b0; ps_end = 1'b0; key_vld = 1'b0; key_num = 4'd0;
    tick(); tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_open();
    test_fail_lockout();
    test_ovf_short();
    test_setcode();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
